// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e  : FSM encoding (IDLE/WAIT/RESP; the fourth code is unused
//              and recovers to IDLE)
//   ADDR_LSB : position of the word index within a byte address
//   idxWidth : number of word-index bits for a given storage depth
package dmem_pkg;

    localparam int ADDR_LSB = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_BAD  = 2'd3
    } state_e;

    // A depth of one word still needs a one-bit index to stay a legal vector.
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage.
//   clk_i   : clock
//   rst_i   : asynchronous active-low reset (clears the read register only)
//   en_i    : access enable; nothing happens unless it is high
//   we_i    : 1 = write wdata_i into word idx_i, 0 = read word idx_i
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data; holds its value between reads
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic                               we_i,
    input  logic [idxWidth(DEPTH_WORDS)-1:0]   idx_i,
    input  logic [31:0]                        wdata_i,
    output logic [31:0]                        rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port. Serves one load or store at a
// time over a req/ack handshake with a fixed access latency, stalls the
// pipeline while busy and reports misaligned or out-of-range addresses.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   req_i   : request strobe, sampled only in IDLE
//   we_i    : 1 = store, 0 = load (sampled with req_i)
//   addr_i  : byte address
//   wdata_i : store data (sampled with req_i)
//   ack_o   : one-cycle completion pulse
//   rdata_o : load data, updated only by a successful load
//   busy_o  : registered stall, high while not IDLE
//   err_o   : error qualifier, only ever high together with ack_o
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int IDX_W = idxWidth(DEPTH_WORDS);

    // Counter preload so the commit edge lands LATENCY-1 edges after accept.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic               reqWe_q;
    logic [IDX_W-1:0]   reqIdx_q;
    logic [31:0]        reqWdata_q;
    logic               ack_q;
    logic               err_q;
    logic               busy_q;

    logic               reqErr;
    logic [IDX_W-1:0]   addrIdx;
    logic               arrEn;
    logic               arrWe;
    logic [IDX_W-1:0]   arrIdx;
    logic [31:0]        arrWdata;

    assign addrIdx = addr_i[ADDR_LSB +: IDX_W];

    // The range check uses the full word address, not just the index bits,
    // so aliases beyond the storage are rejected instead of wrapping.
    assign reqErr = (addr_i[ADDR_LSB-1:0] != '0) ||
                    ({{ADDR_LSB{1'b0}}, addr_i[31:ADDR_LSB]} >= 32'(DEPTH_WORDS));

    // Storage is enabled only on the commit edge. With LATENCY=1 the commit
    // edge is the accept edge itself, so the array is fed straight from the
    // request inputs; otherwise it is fed from the captured request.
    always_comb begin
        arrEn    = 1'b0;
        arrWe    = reqWe_q;
        arrIdx   = reqIdx_q;
        arrWdata = reqWdata_q;
        case (state_q)
            S_IDLE: begin
                if (LATENCY == 1) begin
                    arrEn    = req_i && !reqErr;
                    arrWe    = we_i;
                    arrIdx   = addrIdx;
                    arrWdata = wdata_i;
                end
            end
            S_WAIT: begin
                arrEn = (cnt_q == 4'd0);
            end
            default: begin
                arrEn = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            reqWe_q    <= 1'b0;
            reqIdx_q   <= '0;
            reqWdata_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        reqWe_q    <= we_i;
                        reqIdx_q   <= addrIdx;
                        reqWdata_q <= wdata_i;
                        busy_q     <= 1'b1;
                        // Errors bypass the latency entirely.
                        if (reqErr || (LATENCY == 1)) begin
                            state_q <= S_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= reqErr;
                        end else begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        ack_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) uArray (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (arrEn),
        .we_i    (arrWe),
        .idx_i   (arrIdx),
        .wdata_i (arrWdata),
        .rdata_o (rdata_o)
    );

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. Two instances share the clock,
// reset and request bus: one built with LATENCY=4, one with LATENCY=1.
// 'sel' steers req_i to one of them and picks whose outputs are observed.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;

    logic        ack4, busy4, err4;
    logic [31:0] rdata4;
    logic        ack1, busy1, err1;
    logic [31:0] rdata1;

    logic        ack, busy, err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ack   = sel ? ack1   : ack4;
    assign busy  = sel ? busy1  : busy4;
    assign err   = sel ? err1   : err4;
    assign rdata = sel ? rdata1 : rdata4;

    dmem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (4)
    ) dut4 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req && !sel),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack4),
        .rdata_o (rdata4),
        .busy_o  (busy4),
        .err_o   (err4)
    );

    dmem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (1)
    ) dut1 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req && sel),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .ack_o   (ack1),
        .rdata_o (rdata1),
        .busy_o  (busy1),
        .err_o   (err1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        req   = r;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    // One complete access: raise req at a falling edge, hold it until ack,
    // count rising edges from the accept edge (edge 1) until ack is seen.
    task automatic runAccess(input string tag, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input int lat, input logic expErr,
                             input logic [31:0] expRdata);
        int   n;
        logic seen;
        @(negedge clk);
        applyStimulus(1'b1, w, a, d);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            if (ack) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput({tag, " ack timeout"}, 32'd0, 32'd1);
            applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        end else begin
            checkOutput({tag, " latency"}, 32'(n), 32'(lat));
            checkOutput({tag, " err"}, 32'(err), 32'(expErr));
            checkOutput({tag, " rdata"}, rdata, expRdata);
            applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            checkOutput({tag, " ack pulse"}, 32'(ack), 32'd0);
            checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sel   = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #2 rst_n = 1'b0;

        // Reset, then ten idle cycles with no activity on either instance.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle outputs", {29'd0, ack4 | ack1, busy4 | busy1, err4 | err1}, 32'd0);
        end
        checkOutput("reset rdata4", rdata4, 32'd0);
        checkOutput("reset rdata1", rdata1, 32'd0);

        // Store then load through the LATENCY=4 instance.
        runAccess("store 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 4, 1'b0, 32'h0);
        runAccess("load 0x10", 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hDEADBEEF);

        // Misaligned load errors out in one cycle and leaves rdata alone.
        runAccess("misaligned", 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'hDEADBEEF);
        runAccess("reload 0x10", 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hDEADBEEF);

        // Out-of-range store must not alias onto word 0.
        runAccess("store 0x0", 1'b1, 32'h0, 32'h0, 4, 1'b0, 32'hDEADBEEF);
        runAccess("oor store", 1'b1, 32'h400, 32'h1, 1, 1'b1, 32'hDEADBEEF);
        runAccess("load 0x0", 1'b0, 32'h0, 32'h0, 4, 1'b0, 32'h0);

        // Held request: three back-to-back loads of word 0, acks at edges 4/9/14.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            checkOutput($sformatf("held ack c%0d", c), 32'(ack),
                        32'((c == 4) || (c == 9) || (c == 14)));
            checkOutput($sformatf("held busy c%0d", c), 32'(busy),
                        32'(!((c == 5) || (c == 10) || (c >= 15))));
            if (c == 14) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        end
        checkOutput("held rdata", rdata, 32'h0);

        // Reset two cycles after accepting a store, before its commit edge.
        runAccess("store 0x20", 1'b1, 32'h20, 32'h0, 4, 1'b0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        checkOutput("pre-abort busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort ack", 32'(ack), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post-abort ack", 32'(ack), 32'd0);
        end
        runAccess("load 0x20", 1'b0, 32'h20, 32'h0, 4, 1'b0, 32'h0);

        // LATENCY=1 instance: store/load pair plus one error.
        sel = 1'b1;
        runAccess("l1 store 0x4", 1'b1, 32'h4, 32'h12345678, 1, 1'b0, 32'h0);
        runAccess("l1 load 0x4", 1'b0, 32'h4, 32'h0, 1, 1'b0, 32'h12345678);
        runAccess("l1 misaligned", 1'b0, 32'h6, 32'h0, 1, 1'b1, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
